// File: rtl/ram_bus_ctrl_pkg.sv
// Shared definitions for the RAM bus controller: FSM states, access-size
// codes and the alignment helpers used by the controller and lane steering.
package ram_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef logic [1:0] size_code_t;

  localparam size_code_t SIZE_BYTE = 2'b00;
  localparam size_code_t SIZE_HALF = 2'b01;
  localparam size_code_t SIZE_WORD = 2'b10;

  // Code 11 has no meaning of its own and behaves as a word access.
  function automatic size_code_t norm_size(input size_code_t sz);
    return (sz == 2'b11) ? SIZE_WORD : sz;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input size_code_t sz, input logic [1:0] lo);
    logic mis;
    case (norm_size(sz))
      SIZE_HALF: mis = lo[0];
      SIZE_WORD: mis = (lo != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ram_bus_ctrl_if.sv
// CPU-side request/response signals and RAM-side strobes of the controller.
interface ram_bus_ctrl_if #(
  parameter int RAM_AW = 14
) ();
  import ram_bus_ctrl_pkg::*;

  logic              cs;
  logic              we;
  logic [31:0]       address;
  logic [31:0]       wdata;
  size_code_t        data_size;
  logic [31:0]       rdata;
  logic              ram_ready;
  logic              err;
  logic              busy;
  logic [RAM_AW-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_rdata;

  // Requester side: the CPU plus the RAM returning read data.
  modport master (
    output cs, we, address, wdata, data_size, mem_rdata,
    input  rdata, ram_ready, err, busy, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr
  );

  // Controller side.
  modport slave (
    input  cs, we, address, wdata, data_size, mem_rdata,
    output rdata, ram_ready, err, busy, mem_addr, mem_be, mem_wdata, mem_rd, mem_wr
  );

endinterface

// File: rtl/ram_bus_ctrl_lane_align.sv
// Combinational byte-lane steering: write enables and replicated write data
// for the addressed lanes, and right-justified extraction of read data.
module lane_align
  import ram_bus_ctrl_pkg::*;
(
  input  size_code_t  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wr_be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rd_data
);

  size_code_t size_n;
  assign size_n = norm_size(size);

  // Per-lane enable and write data; a halfword occupies lanes {1,0} or {3,2}.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign wr_be[gi] = (size_n == SIZE_BYTE) ? (addr_lo == LANE) :
                       (size_n == SIZE_HALF) ? (addr_lo[1] == LANE[1]) : 1'b1;
    assign lane_wdata[8*gi +: 8] = (size_n == SIZE_BYTE) ? wdata[7:0] :
                                   (size_n == SIZE_HALF) ? wdata[8*(gi%2) +: 8] :
                                                           wdata[8*gi +: 8];
  end

  // Shift the addressed lane(s) down to bit 0 and zero the upper bits.
  always_comb begin
    rd_data = mem_rdata;
    case (size_n)
      SIZE_BYTE: rd_data = {24'h0, mem_rdata[{addr_lo, 3'b000} +: 8]};
      SIZE_HALF: rd_data = {16'h0, mem_rdata[{addr_lo[1], 4'b0000} +: 16]};
      default:   rd_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/ram_bus_ctrl.sv
// RAM bus controller: accepts one CPU access at a time, optionally waits,
// issues a single-cycle RAM strobe and reports completion with ram_ready.
module ram_bus_ctrl
  import ram_bus_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int RAM_AW      = 14
) (
  input logic         clk,
  input logic         rst,
  ram_bus_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                we_reg;
  logic [RAM_AW+1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  size_code_t          size_reg;
  logic                mis_reg;
  logic [31:0]         rdata_reg, rdata_next;
  logic                accept;
  logic [3:0]          lane_be;
  logic [31:0]         lane_wdata;
  logic [31:0]         lane_rdata;
  logic                unused_addr_hi;

  // Address bits above the RAM word range are deliberately dropped.
  assign unused_addr_hi = ^bus.address[31:RAM_AW+2];

  // A request is only looked at while idle; anything else is dropped.
  assign accept = (state_reg == ST_IDLE) && bus.cs;

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; misaligned requests skip straight to DONE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.cs) begin
          cnt_next = 4'd0;
          if (is_misaligned(bus.data_size, bus.address[1:0])) begin
            state_next = ST_DONE;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next = ST_ACCESS;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Capture the request fields at acceptance; they stay stable for the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      size_reg  <= SIZE_BYTE;
      mis_reg   <= 1'b0;
    end else if (accept) begin
      we_reg    <= bus.we;
      addr_reg  <= bus.address[RAM_AW+1:0];
      wdata_reg <= bus.wdata;
      size_reg  <= bus.data_size;
      mis_reg   <= is_misaligned(bus.data_size, bus.address[1:0]);
    end
  end

  lane_align u_lane_align (
    .size       (size_reg),
    .addr_lo    (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .mem_rdata  (bus.mem_rdata),
    .wr_be      (lane_be),
    .lane_wdata (lane_wdata),
    .rd_data    (lane_rdata)
  );

  // Read data is presented during DONE and held afterwards until the next read.
  always_comb begin
    rdata_next = rdata_reg;
    if ((state_reg == ST_DONE) && !we_reg && !mis_reg) begin
      rdata_next = lane_rdata;
    end
  end

  // Held copy of the last completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= 32'h0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  // Status and RAM strobes decoded from the current state.
  always_comb begin
    bus.busy      = (state_reg != ST_IDLE);
    bus.ram_ready = (state_reg == ST_DONE);
    bus.err       = (state_reg == ST_DONE) && mis_reg;
    bus.mem_rd    = (state_reg == ST_ACCESS) && !we_reg;
    bus.mem_wr    = (state_reg == ST_ACCESS) && we_reg;
    bus.mem_be    = 4'b0000;
    if (state_reg == ST_ACCESS) begin
      bus.mem_be = we_reg ? lane_be : 4'b1111;
    end
    bus.rdata     = rdata_next;
    bus.mem_addr  = addr_reg[RAM_AW+1:2];
    bus.mem_wdata = lane_wdata;
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench: one controller with two wait states and one with none,
// each attached to a small behavioural synchronous RAM.
module tb_ram_bus_ctrl;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  logic [31:0] ram0 [0:(1<<AW)-1];
  logic [31:0] ram1 [0:(1<<AW)-1];

  ram_bus_ctrl_if #(.RAM_AW(AW)) bus0 ();
  ram_bus_ctrl_if #(.RAM_AW(AW)) bus1 ();

  ram_bus_ctrl #(.WAIT_STATES(2), .RAM_AW(AW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ram_bus_ctrl #(.WAIT_STATES(0), .RAM_AW(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Behavioural synchronous RAMs with byte enables.
  always @(posedge clk) begin
    if (bus0.mem_wr)
      for (int i = 0; i < 4; i++)
        if (bus0.mem_be[i]) ram0[bus0.mem_addr][8*i +: 8] <= bus0.mem_wdata[8*i +: 8];
    if (bus0.mem_rd) bus0.mem_rdata <= ram0[bus0.mem_addr];
  end

  always @(posedge clk) begin
    if (bus1.mem_wr)
      for (int j = 0; j < 4; j++)
        if (bus1.mem_be[j]) ram1[bus1.mem_addr][8*j +: 8] <= bus1.mem_wdata[8*j +: 8];
    if (bus1.mem_rd) bus1.mem_rdata <= ram1[bus1.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"},     bus0.rdata, 32'h0);
    check({tag, "_ram_ready"}, 32'(bus0.ram_ready), 32'h0);
    check({tag, "_err"},       32'(bus0.err), 32'h0);
    check({tag, "_busy"},      32'(bus0.busy), 32'h0);
    check({tag, "_mem_rd"},    32'(bus0.mem_rd), 32'h0);
    check({tag, "_mem_wr"},    32'(bus0.mem_wr), 32'h0);
    check({tag, "_mem_be"},    32'(bus0.mem_be), 32'h0);
    check({tag, "_mem_addr"},  32'(bus0.mem_addr), 32'h0);
    check({tag, "_mem_wdata"}, bus0.mem_wdata, 32'h0);
  endtask

  // One access on the two-wait-state controller, tracked cycle by cycle
  // from acceptance (cycle 0) until ram_ready.
  task automatic run_access(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] sz,
                            input int exp_lat, input logic exp_err, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [AW-1:0] exp_addr,
                            input logic [31:0] exp_rdata);
    int cyc = 0, ready_cyc = -1, strobe_cyc = -1, strobes = 0;
    logic [3:0] be_s = '0;
    logic [31:0] wd_s = '0, rd_s = '0;
    logic [AW-1:0] ad_s = '0;
    logic wr_s = 1'b0, err_s = 1'b0;
    bus0.cs = 1'b1; bus0.we = w; bus0.address = a; bus0.wdata = d; bus0.data_size = sz;
    while (ready_cyc < 0 && cyc < 40) begin
      if (bus0.mem_rd || bus0.mem_wr) begin
        strobes++; strobe_cyc = cyc;
        be_s = bus0.mem_be; wd_s = bus0.mem_wdata; ad_s = bus0.mem_addr; wr_s = bus0.mem_wr;
      end
      if (bus0.ram_ready) begin
        ready_cyc = cyc; err_s = bus0.err; rd_s = bus0.rdata;
      end else begin
        tick(); cyc++; bus0.cs = 1'b0;
      end
    end
    bus0.cs = 1'b0;
    tick();
    check({tag, "_latency"}, 32'(ready_cyc), 32'(exp_lat));
    check({tag, "_err"},     32'(err_s), 32'(exp_err));
    check({tag, "_rdata"},   rd_s, exp_rdata);
    check({tag, "_idle"},    32'(bus0.busy), 32'h0);
    if (exp_err) begin
      check({tag, "_strobes"}, 32'(strobes), 32'd0);
    end else begin
      check({tag, "_strobes"},    32'(strobes), 32'd1);
      check({tag, "_strobe_cyc"}, 32'(strobe_cyc), 32'(exp_lat - 1));
      check({tag, "_is_write"},   32'(wr_s), 32'(w));
      check({tag, "_mem_be"},     32'(be_s), 32'(exp_be));
      check({tag, "_mem_addr"},   32'(ad_s), 32'(exp_addr));
      if (w) check({tag, "_mem_wdata"}, wd_s, exp_wdata);
    end
    $display("txn %-10s we=%0d addr=%08h size=%0d lat=%0d err=%0d rdata=%08h",
             tag, w, a, sz, ready_cyc, err_s, rd_s);
  endtask

  initial begin
    int ready_cnt;
    int strobe_cnt;
    logic [7:0] ready_vec;
    logic [7:0] rd_vec;
    logic [31:0] rd_first;
    logic [31:0] rd_second;

    for (int k = 0; k < (1 << AW); k++) begin
      ram0[k] = 32'h0;
      ram1[k] = 32'h1000_0000 + 32'(k) * 32'h11;
    end
    ram0[0] = 32'hAABBCCDD;
    bus0.cs = 1'b0; bus0.we = 1'b0; bus0.address = '0; bus0.wdata = '0; bus0.data_size = 2'b00;
    bus1.cs = 1'b0; bus1.we = 1'b0; bus1.address = '0; bus1.wdata = '0; bus1.data_size = 2'b00;

    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_busy_ws0", 32'(bus1.busy), 32'h0);
    rst = 1'b0;
    tick();

    //          tag        we    address        wdata          sz     lat err be       mem_wdata      addr  rdata
    run_access("rd_w0",    1'b0, 32'h0000_0000, 32'h0,         2'b10, 4, 0, 4'b1111, 32'h0,         0,    32'hAABBCCDD);
    run_access("wr_w0",    1'b1, 32'h0000_0000, 32'h12345678,  2'b10, 4, 0, 4'b1111, 32'h12345678,  0,    32'hAABBCCDD);
    run_access("rd_h2",    1'b0, 32'h0000_0002, 32'h0,         2'b01, 4, 0, 4'b1111, 32'h0,         0,    32'h00001234);
    run_access("rd_b3",    1'b0, 32'h0000_0003, 32'h0,         2'b00, 4, 0, 4'b1111, 32'h0,         0,    32'h00000012);
    run_access("rd_b1",    1'b0, 32'h0000_0001, 32'h0,         2'b00, 4, 0, 4'b1111, 32'h0,         0,    32'h00000056);
    run_access("wr_b6",    1'b1, 32'h0000_0006, 32'hFFFFFF5A,  2'b00, 4, 0, 4'b0100, 32'h5A5A5A5A,  1,    32'h00000056);
    run_access("wr_h4",    1'b1, 32'h0000_0004, 32'h1234BEEF,  2'b01, 4, 0, 4'b0011, 32'hBEEFBEEF,  1,    32'h00000056);
    run_access("rd_w4",    1'b0, 32'h0000_0004, 32'h0,         2'b10, 4, 0, 4'b1111, 32'h0,         1,    32'h005ABEEF);
    run_access("rd_h6",    1'b0, 32'h0000_0006, 32'h0,         2'b01, 4, 0, 4'b1111, 32'h0,         1,    32'h0000005A);
    run_access("mis_wr_w2",1'b1, 32'h0000_0002, 32'hDEADBEEF,  2'b10, 1, 1, 4'b0000, 32'h0,         0,    32'h0000005A);
    check("mis_ram_word0", ram0[0], 32'h12345678);
    run_access("mis_rd_h1",1'b0, 32'h0000_0001, 32'h0,         2'b01, 1, 1, 4'b0000, 32'h0,         0,    32'h0000005A);
    run_access("wr_wrap",  1'b1, 32'hFFFF_0008, 32'hCAFEF00D,  2'b10, 4, 0, 4'b1111, 32'hCAFEF00D,  2,    32'h0000005A);
    check("wrap_ram_word2", ram0[2], 32'hCAFEF00D);
    run_access("rd_sz11",  1'b0, 32'h0000_0008, 32'h0,         2'b11, 4, 0, 4'b1111, 32'h0,         2,    32'hCAFEF00D);
    run_access("wr_b3",    1'b1, 32'h0000_0003, 32'h00000077,  2'b00, 4, 0, 4'b1000, 32'h77777777,  0,    32'hCAFEF00D);
    run_access("rd_w0b",   1'b0, 32'h0000_0000, 32'h0,         2'b10, 4, 0, 4'b1111, 32'h0,         0,    32'h77345678);

    // Abort: read accepted, extra write pulsed during WAIT, reset during ACCESS.
    bus0.cs = 1'b1; bus0.we = 1'b0; bus0.address = 32'h0; bus0.data_size = 2'b10;
    tick();
    bus0.cs = 1'b1; bus0.we = 1'b1; bus0.wdata = 32'hFFFFFFFF;
    tick();
    bus0.cs = 1'b0;
    tick();
    check("abort_access_rd", 32'(bus0.mem_rd), 32'h1);
    rst = 1'b1;
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    ready_cnt = 0;
    strobe_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus0.ram_ready) ready_cnt++;
      if (bus0.mem_rd || bus0.mem_wr) strobe_cnt++;
    end
    check("abort_ready_cnt", 32'(ready_cnt), 32'h0);
    check("abort_strobe_cnt", 32'(strobe_cnt), 32'h0);
    check("abort_ram_word0", ram0[0], 32'h77345678);
    $display("txn abort      ready=%0d strobes=%0d", ready_cnt, strobe_cnt);

    // Zero wait states, cs held high across two reads.
    ready_vec = '0; rd_vec = '0; rd_first = '0; rd_second = '0;
    bus1.cs = 1'b1; bus1.we = 1'b0; bus1.address = 32'h4; bus1.data_size = 2'b10;
    for (int c = 0; c < 8; c++) begin
      ready_vec[c] = bus1.ram_ready;
      rd_vec[c] = bus1.mem_rd;
      if (c == 2) rd_first = bus1.rdata;
      if (c == 5) rd_second = bus1.rdata;
      if (c == 2) bus1.address = 32'h8;
      if (c == 5) bus1.cs = 1'b0;
      tick();
    end
    check("ws0_ready_cycles", 32'(ready_vec), 32'h24);
    check("ws0_rd_cycles", 32'(rd_vec), 32'h12);
    check("ws0_rdata_first", rd_first, 32'h10000011);
    check("ws0_rdata_second", rd_second, 32'h10000022);
    $display("txn ws0_b2b    ready_vec=%02h rd_vec=%02h rdata=%08h,%08h",
             ready_vec, rd_vec, rd_first, rd_second);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/ram_bus_ctrl.md
RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 2: idle cycles inserted before the RAM strobe; legal range 0..15.
REQ-002 Parameter RAM_AW, default 14: RAM word-address width.
REQ-003 clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cs  in  1  CPU request strobe, sampled only in IDLE.
REQ-006 we  in  1  1 = write, 0 = read; sampled with cs.
REQ-007 address  in  32  byte address; sampled with cs.
REQ-008 wdata  in  32  write data, right-justified; sampled with cs.
REQ-009 data_size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-010 rdata  out  32  read data, right-justified and zero-extended.
REQ-011 ram_ready  out  1  one-cycle completion pulse to the CPU.
REQ-012 err  out  1  misalignment flag, valid only while ram_ready=1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 mem_addr  out  RAM_AW  word address, taken from address[RAM_AW+1:2].
REQ-015 mem_be  out  4  byte-lane enables; lane i covers bits 8i+7:8i.
REQ-016 mem_wdata  out  32  lane-aligned write data.
REQ-017 mem_rd, mem_wr  out  1 each  single-cycle RAM strobes.
REQ-018 mem_rdata  in  32  synchronous RAM output, valid the cycle after mem_rd.

Function
REQ-019 The FSM SHALL have the states IDLE, WAIT, ACCESS and DONE.
REQ-020 In IDLE with cs=1, the block SHALL latch we, address, wdata and data_size, then:
  - go to DONE with err=1 if the access is misaligned;
  - otherwise go to WAIT if WAIT_STATES>0, or to ACCESS if WAIT_STATES=0.
REQ-021 An access is misaligned when it is a halfword with address[0]=1, or a word with address[1:0]!=0; bytes are never misaligned.
REQ-022 WAIT SHALL last exactly WAIT_STATES cycles, counted by a counter that is cleared on entry, then go to ACCESS.
REQ-023 ACCESS SHALL last one cycle:
  - reads: mem_rd=1 and mem_be=1111;
  - writes: mem_wr=1 with the size-dependent mem_be;
  - then go to DONE.
REQ-024 Write byte enables SHALL be:
  - byte: 0001 shifted left by address[1:0];
  - halfword: 0011 shifted left by address[1]*2;
  - word: 1111.
REQ-025 mem_wdata SHALL replicate wdata[7:0] into all four lanes for a byte, wdata[15:0] into both halves for a halfword, and pass wdata unchanged for a word.
REQ-026 In DONE, a read SHALL register rdata from the addressed lane(s) of mem_rdata, shifted down and zero-extended; the upper bits SHALL be 0 for byte and halfword.
REQ-027 DONE SHALL assert ram_ready=1 for exactly one cycle, then return to IDLE.
REQ-028 Aligned-access latency: with acceptance in cycle 0, ram_ready SHALL be high in cycle WAIT_STATES+2.
REQ-029 Misaligned-access latency: ram_ready and err SHALL be high in cycle 1, with no strobe, no RAM write and rdata unchanged.
REQ-030 cs while busy=1 SHALL be ignored and not queued.
REQ-031 A request held during DONE SHALL be accepted in the following IDLE cycle, giving back-to-back throughput of one access per WAIT_STATES+3 cycles.
REQ-032 mem_rd, mem_wr and mem_be SHALL be 0 outside ACCESS.
REQ-033 rdata SHALL hold its value until the next read completes; a write SHALL leave rdata unchanged.
REQ-034 The word address SHALL wrap modulo 2^RAM_AW; address bits above RAM_AW+1 SHALL be ignored.

Reset
REQ-035 When rst=1 at a clock edge, the state SHALL become IDLE and the counter SHALL clear, including when rst arrives mid-access.
REQ-036 Reset values: rdata=0, ram_ready=0, err=0, busy=0, mem_rd=0, mem_wr=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-037 A request aborted by reset SHALL produce no ram_ready and no further strobe.

Structure
REQ-038 The state encodings and the data_size codes (BYTE=00, HALF=01, WORD=10) SHALL live in the shared package/header used by the memory controller.
REQ-039 Lane steering SHALL be one combinational sub-module, lane_align, which both produces mem_be/mem_wdata and extracts rdata.

Verification
REQ-040 Read, WAIT_STATES=2, RAM word 0x0 = 0xAABBCCDD, word read at address 0x0 -> mem_rd pulse in cycle 3; ram_ready and rdata=0xAABBCCDD in cycle 4.
REQ-041 Byte write of wdata=0x5A at address 0x6 -> mem_be=0100, mem_wdata=0x5A5A5A5A, mem_addr=1, err=0.
REQ-042 Halfword read at address 0x2 of word 0x12345678 -> rdata=0x00001234; byte read at address 0x3 -> rdata=0x00000012.
REQ-043 Word write at address 0x2 -> ram_ready and err in cycle 1; mem_wr never asserted; RAM contents unchanged.
REQ-044 cs pulsed in WAIT, then rst asserted in ACCESS -> second request ignored; all outputs zero the cycle after reset; no ram_ready.
REQ-045 WAIT_STATES=0 with cs held high for two reads -> ram_ready in cycles 2 and 5.
